// File: rtl/stream_filter3x3_if.sv
// FIFO-side handshake bundle for stream_filter3x3: an FWFT read port upstream and a write port downstream.
// The master side is the filter; the slave side is the pair of FIFOs around it.
interface stream_filter3x3_if #(
  parameter int PIX_W = 8
);
  logic             in_rd_en;
  logic [PIX_W-1:0] in_dout;
  logic             in_empty;
  logic             out_wr_en;
  logic [PIX_W-1:0] out_din;
  logic             out_full;

  modport master (
    output in_rd_en, out_wr_en, out_din,
    input  in_dout, in_empty, out_full
  );

  modport slave (
    input  in_rd_en, out_wr_en, out_din,
    output in_dout, in_empty, out_full
  );
endinterface

// File: rtl/stream_filter3x3.sv
// Streaming 3x3 filter (Sobel magnitude, Gaussian blur or pass-through) between two FIFOs.
// Two row buffers feed a sliding window; a single registered result stage drives the output FIFO.
module stream_filter3x3 #(
  parameter int WIDTH  = 720,
  parameter int HEIGHT = 540,
  parameter int PIX_W  = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [1:0]         mode,
  stream_filter3x3_if.master fifo,
  output logic               frame_done,
  output logic               busy
);
  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  localparam int NW = $clog2(WIDTH * HEIGHT + 1);
  localparam int SW = PIX_W + 4;

  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;
  state_t state_reg, state_next;

  logic [PIX_W-1:0] lb0_mem [WIDTH];
  logic [PIX_W-1:0] lb1_mem [WIDTH];
  logic [PIX_W-1:0] rd0_reg, rd1_reg;
  logic [PIX_W-1:0] win_reg  [3][2];
  logic [PIX_W-1:0] win_next [3][3];
  logic [PIX_W-1:0] new_col  [3];
  logic [SW-1:0]    ku       [3][3];

  logic [CW-1:0]    col_reg, col_next;
  logic [CW-1:0]    ctr_col_reg, ctr_col_next;
  logic [RW-1:0]    ctr_row_reg, ctr_row_next;
  logic [NW-1:0]    in_cnt_reg, in_cnt_next;
  logic [1:0]       mode_reg;
  logic             busy_reg, valid_reg, last_reg;
  logic [PIX_W-1:0] result_reg, result_next;
  logic             advance, accept, shift, push, last_ctr, border;

  logic signed [SW-1:0] gx, gy;
  logic [SW-1:0]        ax, ay, half, gsum;
  logic [SW:0]          mag_sum;
  logic [PIX_W-1:0]     sobel_pix, gauss_pix, center;

  assign advance  = ~valid_reg | ~fifo.out_full;
  assign accept   = ~reset & ~fifo.in_empty & advance & (state_reg != FLUSH);
  assign shift    = accept | ((state_reg == FLUSH) & advance);
  assign push     = shift & ((state_reg == RUN) | (state_reg == FLUSH));
  assign last_ctr = (ctr_row_reg == RW'(HEIGHT - 1)) && (ctr_col_reg == CW'(WIDTH - 1));
  assign border   = (ctr_row_reg == '0) || (ctr_row_reg == RW'(HEIGHT - 1)) ||
                    (ctr_col_reg == '0) || (ctr_col_reg == CW'(WIDTH - 1));

  assign fifo.in_rd_en  = accept;
  assign fifo.out_wr_en = valid_reg & ~fifo.out_full;
  assign fifo.out_din   = result_reg;
  assign frame_done     = fifo.out_wr_en & last_reg;
  assign busy           = busy_reg;

  // Flush behaves like accepting zero pixels so the row buffers keep delivering the last row.
  assign new_col[0] = rd1_reg;
  assign new_col[1] = rd0_reg;
  assign new_col[2] = (state_reg == FLUSH) ? '0 : fifo.in_dout;

  // Only two window columns are stored; the third is the column arriving this cycle.
  genvar gi, gj;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_win
      assign win_next[gi][0] = win_reg[gi][0];
      assign win_next[gi][1] = win_reg[gi][1];
      assign win_next[gi][2] = new_col[gi];
      for (gj = 0; gj < 3; gj++) begin : g_ext
        assign ku[gi][gj] = {4'b0000, win_next[gi][gj]};
      end
    end
  endgenerate

  always_comb begin
    gx = ($signed(ku[0][2]) + $signed(ku[1][2]) + $signed(ku[1][2]) + $signed(ku[2][2])) -
         ($signed(ku[0][0]) + $signed(ku[1][0]) + $signed(ku[1][0]) + $signed(ku[2][0]));
    gy = ($signed(ku[2][0]) + $signed(ku[2][1]) + $signed(ku[2][1]) + $signed(ku[2][2])) -
         ($signed(ku[0][0]) + $signed(ku[0][1]) + $signed(ku[0][1]) + $signed(ku[0][2]));
    ax = gx[SW-1] ? $unsigned(-gx) : $unsigned(gx);
    ay = gy[SW-1] ? $unsigned(-gy) : $unsigned(gy);
    mag_sum   = {1'b0, ax} + {1'b0, ay};
    half      = SW'(mag_sum >> 1);
    sobel_pix = (half > SW'((1 << PIX_W) - 1)) ? '1 : PIX_W'(half);
    gsum = ku[0][0] + ku[0][2] + ku[2][0] + ku[2][2] +
           ((ku[0][1] + ku[1][0] + ku[1][2] + ku[2][1]) << 1) + (ku[1][1] << 2);
    gauss_pix = PIX_W'(gsum >> 4);
    center    = win_next[1][1];
    case (mode_reg)
      2'd0:    result_next = border ? '0 : sobel_pix;
      2'd1:    result_next = border ? center : gauss_pix;
      default: result_next = center;
    endcase
  end

  always_comb begin
    state_next   = state_reg;
    in_cnt_next  = in_cnt_reg;
    col_next     = col_reg;
    ctr_col_next = ctr_col_reg;
    ctr_row_next = ctr_row_reg;
    case (state_reg)
      IDLE: if (accept) begin
        state_next  = FILL;
        in_cnt_next = NW'(1);
      end
      FILL: if (accept) begin
        in_cnt_next = in_cnt_reg + 1'b1;
        if (in_cnt_reg == NW'(WIDTH)) state_next = RUN;
      end
      RUN: if (accept) begin
        in_cnt_next = in_cnt_reg + 1'b1;
        if (in_cnt_reg == NW'(WIDTH * HEIGHT - 1)) state_next = FLUSH;
      end
      FLUSH: if (push && last_ctr) begin
        state_next  = IDLE;
        in_cnt_next = '0;
      end
      default: state_next = IDLE;
    endcase
    // The column pointer restarts at 0 for every frame, even though flush overruns a full row.
    if (shift) col_next = ((col_reg == CW'(WIDTH - 1)) || (push && last_ctr)) ? '0 : col_reg + 1'b1;
    if (push) begin
      if (last_ctr) begin
        ctr_col_next = '0;
        ctr_row_next = '0;
      end else if (ctr_col_reg == CW'(WIDTH - 1)) begin
        ctr_col_next = '0;
        ctr_row_next = ctr_row_reg + 1'b1;
      end else begin
        ctr_col_next = ctr_col_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      in_cnt_reg  <= '0;
      col_reg     <= '0;
      ctr_col_reg <= '0;
      ctr_row_reg <= '0;
      mode_reg    <= '0;
      busy_reg    <= 1'b0;
      valid_reg   <= 1'b0;
      last_reg    <= 1'b0;
      result_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      in_cnt_reg  <= in_cnt_next;
      col_reg     <= col_next;
      ctr_col_reg <= ctr_col_next;
      ctr_row_reg <= ctr_row_next;
      if (state_reg == IDLE && accept) begin
        mode_reg <= mode;
        busy_reg <= 1'b1;
      end else if (frame_done) begin
        busy_reg <= 1'b0;
      end
      if (push) begin
        valid_reg  <= 1'b1;
        result_reg <= result_next;
        last_reg   <= last_ctr;
      end else if (fifo.out_wr_en) begin
        valid_reg <= 1'b0;
        last_reg  <= 1'b0;
      end
    end
  end

  // Registered-read row buffers: the read address already points at the next column to be shifted.
  always_ff @(posedge clock) begin
    if (shift) begin
      lb0_mem[col_reg] <= new_col[2];
      lb1_mem[col_reg] <= rd0_reg;
    end
    rd0_reg <= lb0_mem[col_next];
    rd1_reg <= lb1_mem[col_next];
  end

  always_ff @(posedge clock) begin
    if (shift) begin
      for (int r = 0; r < 3; r++) begin
        win_reg[r][0] <= win_reg[r][1];
        win_reg[r][1] <= new_col[r];
      end
    end
  end
endmodule

// File: tb/tb_stream_filter3x3.sv
// Directed bench for stream_filter3x3 on an 8x6 frame: table of whole-frame vectors plus
// hand-written sequences for backpressure, mid-frame reset and back-to-back frames.
`timescale 1ns/1ps
module tb_stream_filter3x3;
  localparam int W = 8, H = 6, PW = 8, N = W * H;
  localparam int P_STEP = 0, P_CONST = 1, P_RAMP = 2, P_RRAMP = 3;
  localparam int E_SOBEL_STEP = 0, E_CONST = 1, E_RAMP = 2, E_SOBEL_RAMP = 3, E_GAUSS_STEP = 4, E_STEP = 5;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] mode;
  logic       frame_done, busy;

  stream_filter3x3_if #(.PIX_W(PW)) fifo_if();

  stream_filter3x3 #(.WIDTH(W), .HEIGHT(H), .PIX_W(PW)) dut (
    .clock(clock), .reset(reset), .mode(mode), .fifo(fifo_if),
    .frame_done(frame_done), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0] mode;
    int         pat;
    int         exp;
    bit         rnd;
  } vec_t;
  vec_t vecs[7];

  int n_cmp = 0, n_bad = 0;
  logic [PW-1:0] src_q[$];
  logic [PW-1:0] got_q[$];
  logic [PW-1:0] exp_q[$];
  int  fd_pos[$];
  int  src_idx, first_wr_idx, stall_at, mode_sw_at;
  int  unstable, wr_in_stall, rd_in_stall;
  bit  empty_rand, stall_seen;
  logic [1:0] mode_a, mode_b;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  function automatic logic [PW-1:0] pat(input int kind, input int n);
    int c;
    c = n % W;
    case (kind)
      P_STEP:  return (c >= 4) ? 8'd200 : 8'd0;
      P_CONST: return 8'd100;
      P_RAMP:  return PW'(n);
      default: return PW'(N - 1 - n);
    endcase
  endfunction

  function automatic logic [PW-1:0] expv(input int kind, input int n);
    int r, c;
    bit bd;
    r  = n / W;
    c  = n % W;
    bd = (r == 0) || (r == H - 1) || (c == 0) || (c == W - 1);
    case (kind)
      E_SOBEL_STEP: return (!bd && (c == 3 || c == 4)) ? 8'd255 : 8'd0;
      E_CONST:      return 8'd100;
      E_RAMP:       return PW'(n);
      E_SOBEL_RAMP: return bd ? 8'd0 : 8'd36;
      E_GAUSS_STEP: begin
        if (bd) return (c >= 4) ? 8'd200 : 8'd0;
        if (c == 3) return 8'd50;
        if (c == 4) return 8'd150;
        return (c >= 5) ? 8'd200 : 8'd0;
      end
      default:      return (c >= 4) ? 8'd200 : 8'd0;
    endcase
  endfunction

  task automatic start_test();
    src_q.delete(); got_q.delete(); exp_q.delete(); fd_pos.delete();
    src_idx = 0; first_wr_idx = -1; stall_at = -1; mode_sw_at = 1 << 30;
    unstable = 0; wr_in_stall = 0; rd_in_stall = 0; stall_seen = 0; empty_rand = 0;
  endtask

  task automatic add_frame(input int p, input int e);
    for (int n = 0; n < N; n++) begin
      src_q.push_back(pat(p, n));
      exp_q.push_back(expv(e, n));
    end
  endtask

  // Cycle loop: drive at negedge, sample 1 ns later, well away from the active edge.
  task automatic drive(input int stop_idx, input int max_cyc);
    int cyc = 0, stall_left = 0, tail = 0;
    bit prev_stall = 0, prev_rd = 0, stall_done = 0, done = 0;
    logic [PW-1:0] prev_dout = '0;
    while (!done) begin
      @(negedge clock);
      mode = (src_idx >= mode_sw_at) ? mode_b : mode_a;
      if (stall_at >= 0 && !stall_done && got_q.size() == stall_at) begin
        stall_left = 20;
        stall_done = 1;
      end
      fifo_if.out_full = (stall_left > 0);
      fifo_if.in_empty = (src_idx >= src_q.size()) || (empty_rand && ($urandom_range(0, 2) == 0));
      fifo_if.in_dout  = (src_idx < src_q.size()) ? src_q[src_idx] : PW'($urandom);
      #1;
      if (fifo_if.out_full) begin
        stall_seen = 1;
        if (fifo_if.out_wr_en) wr_in_stall++;
        if (fifo_if.in_rd_en) rd_in_stall++;
        if (prev_stall && !prev_rd && fifo_if.out_din != prev_dout) unstable++;
      end
      prev_stall = fifo_if.out_full;
      prev_rd    = fifo_if.in_rd_en;
      prev_dout  = fifo_if.out_din;
      if (fifo_if.out_wr_en) begin
        if (first_wr_idx < 0) first_wr_idx = src_idx;
        got_q.push_back(fifo_if.out_din);
      end
      if (frame_done) fd_pos.push_back(got_q.size());
      if (fifo_if.in_rd_en) src_idx++;
      if (stall_left > 0) stall_left--;
      cyc++;
      if (tail > 0) begin
        tail--;
        if (tail == 0) done = 1;
      end else if (src_idx >= stop_idx) begin
        done = 1;
      end else if (src_idx >= src_q.size() && got_q.size() >= exp_q.size()) begin
        tail = 8;
      end else if (cyc >= max_cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL drive_timeout: got %0d writes after %0d cycles, required %0d", got_q.size(), cyc, exp_q.size());
        done = 1;
      end
    end
  endtask

  task automatic check_frames(input string tag, input int nframes);
    int bad0 = n_bad;
    check({tag, "_writes"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_pix%0d", tag, i), got_q[i], exp_q[i]);
    check({tag, "_frame_done_count"}, fd_pos.size(), nframes);
    for (int k = 0; k < fd_pos.size() && k < nframes; k++)
      check($sformatf("%s_frame_done_pos%0d", tag, k), fd_pos[k], (k + 1) * N);
    check({tag, "_busy_after"}, busy, 0);
    $display("frame %s: %0d writes, %0d frame_done, %0d bad", tag, got_q.size(), fd_pos.size(), n_bad - bad0);
  endtask

  // Reset is asserted away from the clock edge; outputs must clear without waiting for one.
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    fifo_if.in_empty = 1'b0;
    fifo_if.out_full = 1'b0;
    fifo_if.in_dout  = 8'h55;
    repeat (3) begin
      #1;
      check("reset_ctrl", {fifo_if.in_rd_en, fifo_if.out_wr_en, frame_done, busy}, 0);
      check("reset_dout", fifo_if.out_din, 0);
      @(negedge clock);
    end
    reset = 1'b0;
    fifo_if.in_empty = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    mode  = 2'd0;
    fifo_if.in_empty = 1'b1;
    fifo_if.out_full = 1'b0;
    fifo_if.in_dout  = '0;
    vecs[0] = '{2'd0, P_STEP,  E_SOBEL_STEP, 1'b0};
    vecs[1] = '{2'd1, P_CONST, E_CONST,      1'b0};
    vecs[2] = '{2'd2, P_RAMP,  E_RAMP,       1'b0};
    vecs[3] = '{2'd0, P_RAMP,  E_SOBEL_RAMP, 1'b0};
    vecs[4] = '{2'd0, P_RRAMP, E_SOBEL_RAMP, 1'b1};
    vecs[5] = '{2'd1, P_STEP,  E_GAUSS_STEP, 1'b0};
    vecs[6] = '{2'd3, P_STEP,  E_STEP,       1'b1};

    do_reset();

    for (int i = 0; i < 7; i++) begin
      start_test();
      mode_a = vecs[i].mode;
      mode_b = vecs[i].mode;
      empty_rand = vecs[i].rnd;
      add_frame(vecs[i].pat, vecs[i].exp);
      drive(1 << 30, 2000);
      check_frames($sformatf("vec%0d", i), 1);
      if (!vecs[i].rnd) check($sformatf("vec%0d_first_write_after_pixels", i), first_wr_idx, W + 2);
    end

    // Backpressure: 20-cycle out_full hold mid-RUN with random upstream gaps.
    start_test();
    mode_a = 2'd0; mode_b = 2'd0;
    empty_rand = 1;
    stall_at = 10;
    add_frame(P_RAMP, E_SOBEL_RAMP);
    drive(1 << 30, 3000);
    check_frames("stall", 1);
    check("stall_seen", stall_seen, 1);
    check("stall_dout_unstable", unstable, 0);
    check("stall_writes_while_full", wr_in_stall, 0);
    check("stall_reads_le1", (rd_in_stall <= 1) ? 1 : 0, 1);

    // Reset after 30 accepted pixels, then a clean Sobel-step frame.
    start_test();
    mode_a = 2'd1; mode_b = 2'd1;
    add_frame(P_STEP, E_SOBEL_STEP);
    drive(30, 500);
    check("abort_pixels_accepted", src_idx, 30);
    do_reset();
    start_test();
    mode_a = 2'd0; mode_b = 2'd0;
    add_frame(P_STEP, E_SOBEL_STEP);
    drive(1 << 30, 2000);
    check_frames("after_reset", 1);

    // Back-to-back frames; mode flips to Gaussian at pixel 20 of frame 1.
    start_test();
    mode_a = 2'd0; mode_b = 2'd1;
    mode_sw_at = 20;
    add_frame(P_STEP, E_SOBEL_STEP);
    add_frame(P_STEP, E_GAUSS_STEP);
    drive(1 << 30, 4000);
    check_frames("b2b", 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
